// File: rtl/dly_sched_pkg.sv
// Shared types and defaults for the dly_sched delay-slot scheduler.
package dly_sched_pkg;

  localparam int unsigned NreqDefault  = 8;
  localparam int unsigned NslotDefault = 4;
  localparam int unsigned CwDefault    = 13;

  // One tick is one clk period.
  localparam int unsigned TickNs = 20;

  localparam int unsigned OwnerW = (NreqDefault > 1) ? $clog2(NreqDefault) : 1;

  // Countdown slot record.
  typedef struct packed {
    logic                 valid;
    logic [OwnerW-1:0]    owner;
    logic [CwDefault-1:0] cnt;
  } slot_t;

endpackage

// File: rtl/dly_sched_rrarb.sv
// Round-robin arbiter: one-hot grant, pointer moves just past the winner on grant.
module dly_sched_rrarb #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] sel;
  logic          found;

  // Search upward from the pointer, wrapping, for the first requester.
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    sel   = '0;
    if (en) begin
      for (int unsigned k = 0; k < N; k++) begin
        sel = PW'((32'(ptr_q) + k) % N);
        if (!found && req[sel]) begin
          gnt[sel] = 1'b1;
          found    = 1'b1;
          ptr_d    = PW'((32'(sel) + 1) % N);
        end
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dly_sched.sv
// Shared delay-slot scheduler: NREQ requesters share NSLOT countdown slots.
// Optional abort support is compiled in with `define DLY_SCHED_ABORT_EN.
module dly_sched
  import dly_sched_pkg::*;
#(
  parameter int unsigned NREQ  = NreqDefault,
  parameter int unsigned NSLOT = NslotDefault,
  parameter int unsigned CW    = CwDefault
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*CW-1:0] cfg_dly,
  input  logic [NREQ-1:0]   abort,
  output logic [NREQ-1:0]   p,
  output logic [NREQ-1:0]   l,
  output logic              full
);

  localparam int unsigned SW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam logic [CW-1:0] One = CW'(1);
  localparam logic [CW-1:0] Two = CW'(2);

  // The slot record is sized from the package defaults.
  if (NREQ > (1 << OwnerW) || CW != CwDefault) begin : g_param_check
    $error("dly_sched: NREQ/CW do not fit the package slot record");
  end

  slot_t [NSLOT-1:0] slot_q, slot_d;
  logic [NREQ-1:0]   pend_q, pend_d;
  logic [NREQ-1:0]   p_q, p_d;
  logic [CW-1:0]     dly [NREQ];
  logic [NREQ-1:0]   nz, owned, retrig, newreq, cand, gnt, kill;
  logic [NSLOT-1:0]  vld;
  logic [SW-1:0]     free_idx;
  logic              any_free;
  logic [OwnerW-1:0] win_idx;
  logic [OwnerW-1:0] own;

`ifdef DLY_SCHED_ABORT_EN
  assign kill = abort;
`else
  logic abort_unused;
  assign abort_unused = ^abort;
  assign kill = '0;
`endif

  // Per-requester delay, ownership and request classification.
  always_comb begin
    owned = '0;
    vld   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      dly[i] = cfg_dly[i*CW +: CW];
      nz[i]  = |dly[i];
    end
    for (int unsigned s = 0; s < NSLOT; s++) begin
      vld[s] = slot_q[s].valid;
      if (slot_q[s].valid) owned[slot_q[s].owner] = 1'b1;
    end
    // A zero delay is dropped outright; an owner's req restarts its own slot.
    retrig = req & nz & owned & ~kill;
    newreq = req & nz & ~owned & ~kill;
    cand   = (newreq | pend_q) & ~kill;
  end

  // Lowest-index free slot.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int unsigned s = 0; s < NSLOT; s++) begin
      if (!slot_q[s].valid && !any_free) begin
        any_free = 1'b1;
        free_idx = SW'(s);
      end
    end
  end

  dly_sched_rrarb #(
    .N (NREQ)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (any_free),
    .req     (cand),
    .gnt     (gnt)
  );

  // Encode the one-hot grant.
  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) win_idx = OwnerW'(i);
    end
  end

  // Slot countdown, retrigger, allocation and expiry-pulse generation.
  // p is registered one edge before the cnt==1 cycle so it coincides with it.
  always_comb begin
    slot_d = slot_q;
    p_d    = '0;
    own    = '0;
    for (int unsigned s = 0; s < NSLOT; s++) begin
      if (slot_q[s].valid) begin
        own = slot_q[s].owner;
        if (retrig[own]) begin
          slot_d[s].cnt = dly[own];
          if (dly[own] == One) p_d[own] = 1'b1;
        end else if (slot_q[s].cnt == One) begin
          slot_d[s].valid = 1'b0;
        end else begin
          slot_d[s].cnt = slot_q[s].cnt - One;
          if (slot_q[s].cnt == Two) p_d[own] = 1'b1;
        end
        if (kill[own]) slot_d[s].valid = 1'b0;
      end
    end
    // Winner loads its delay as sampled now; a delay gone to zero is dropped.
    if (any_free && (|gnt) && nz[win_idx]) begin
      slot_d[free_idx].valid = 1'b1;
      slot_d[free_idx].owner = win_idx;
      slot_d[free_idx].cnt   = dly[win_idx];
      if (dly[win_idx] == One) p_d[win_idx] = 1'b1;
    end
    p_d    = p_d & ~kill;
    pend_d = (pend_q | newreq) & ~gnt & ~kill;
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q <= '0;
      pend_q <= '0;
      p_q    <= '0;
    end else begin
      slot_q <= slot_d;
      pend_q <= pend_d;
      p_q    <= p_d;
    end
  end

  assign p    = p_q;
  assign l    = pend_q | owned;
  assign full = &vld;

endmodule

// File: tb/tb_dly_sched.sv
// Directed self-checking bench for dly_sched.
module tb_dly_sched;
  import dly_sched_pkg::*;

  localparam int unsigned NREQ  = 8;
  localparam int unsigned NSLOT = 4;
  localparam int unsigned CW    = 13;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ-1:0]      abort = '0;
  logic [NREQ*CW-1:0]   cfg_dly = '0;
  logic [NREQ-1:0]      p;
  logic [NREQ-1:0]      l;
  logic                 full;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pcnt [NREQ];
  int pfirst [NREQ];
  int plast [NREQ];

  dly_sched #(
    .NREQ  (NREQ),
    .NSLOT (NSLOT),
    .CW    (CW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .cfg_dly (cfg_dly),
    .abort   (abort),
    .p       (p),
    .l       (l),
    .full    (full)
  );

  always #(TickNs / 2) clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder, sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (p[i] === 1'b1) begin
        if (pcnt[i] == 0) pfirst[i] = cyc;
        plast[i] = cyc;
        pcnt[i]  = pcnt[i] + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    for (int i = 0; i < NREQ; i++) begin
      pcnt[i]   = 0;
      pfirst[i] = -1;
      plast[i]  = -1;
    end
  endtask

  task automatic set_dly(input int i, input int d);
    cfg_dly[i*CW +: CW] = CW'(d);
  endtask

  // Drive req for the current cycle; returns one cycle later.
  task automatic pulse(input logic [NREQ-1:0] m);
    req = m;
    tick();
    req = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    if (p !== 8'h00) begin $display("FAIL reset_p: got %b want %b", p, 8'h00); bad++; end
    total++;
    if (l !== 8'h00) begin $display("FAIL reset_l: got %b want %b", l, 8'h00); bad++; end
    total++;
    if (full !== 1'b0) begin $display("FAIL reset_full: got %b want 0", full); bad++; end
    total++;
    reset_n = 1'b1;
    tick();
    if (l !== 8'h00) begin $display("FAIL post_reset_l: got %b want %b", l, 8'h00); bad++; end
    total++;
  endtask

  task automatic test_single();
    int base;
    logic exp_l;
    repeat (10) tick();
    set_dly(2, 5);
    clr_mon();
    base = cyc;
    pulse(8'h04);
    for (int k = 1; k <= 8; k++) begin
      exp_l = (k <= 5);
      if (l[2] !== exp_l) begin
        $display("FAIL single_l2 cycle+%0d: got %b want %b", k, l[2], exp_l); bad++;
      end
      total++;
      tick();
    end
    if (pcnt[2] != 1) begin $display("FAIL single_pcnt: got %0d want 1", pcnt[2]); bad++; end
    total++;
    if (pfirst[2] != base + 5) begin
      $display("FAIL single_pcyc: got %0d want %0d", pfirst[2], base + 5); bad++;
    end
    total++;
    if (pcnt[0] + pcnt[1] + pcnt[3] + pcnt[4] + pcnt[5] + pcnt[6] + pcnt[7] != 0) begin
      $display("FAIL single_other_p: got nonzero want 0"); bad++;
    end
    total++;
  endtask

  task automatic test_boundary();
    int base;
    int n;
    // D=1
    set_dly(6, 1);
    clr_mon();
    base = cyc;
    pulse(8'h40);
    tick();
    tick();
    if (pcnt[6] != 1 || pfirst[6] != base + 1) begin
      $display("FAIL d1_p: got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", pcnt[6], pfirst[6], base + 1);
      bad++;
    end
    total++;
    // D=0
    set_dly(7, 0);
    clr_mon();
    pulse(8'h80);
    for (int k = 0; k < 4; k++) begin
      if (l[7] !== 1'b0) begin $display("FAIL d0_l: got %b want 0", l[7]); bad++; end
      total++;
      tick();
    end
    if (pcnt[7] != 0) begin $display("FAIL d0_p: got %0d want 0", pcnt[7]); bad++; end
    total++;
    // D=max
    set_dly(5, 8191);
    clr_mon();
    base = cyc;
    pulse(8'h20);
    n = 0;
    while (cyc < base + 8195 && n < 9000) begin
      tick();
      n++;
    end
    if (pcnt[5] != 1 || pfirst[5] != base + 8191) begin
      $display("FAIL dmax_p: got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", pcnt[5], pfirst[5],
               base + 8191);
      bad++;
    end
    total++;
  endtask

  task automatic test_contention();
    int base;
    int exp_c [6];
    exp_c = '{20, 21, 22, 23, 41, 42};
    for (int i = 0; i < 6; i++) set_dly(i, 20);
    clr_mon();
    base = cyc;
    pulse(8'h3F);
    tick();
    tick();
    if (full !== 1'b0) begin $display("FAIL cont_full_c3: got %b want 0", full); bad++; end
    total++;
    tick();
    if (full !== 1'b1) begin $display("FAIL cont_full_c4: got %b want 1", full); bad++; end
    total++;
    if (l[5] !== 1'b1) begin $display("FAIL cont_l5_pending: got %b want 1", l[5]); bad++; end
    total++;
    while (cyc < base + 21) tick();
    if (full !== 1'b0) begin $display("FAIL cont_full_c21: got %b want 0", full); bad++; end
    total++;
    while (cyc < base + 46) tick();
    for (int i = 0; i < 6; i++) begin
      if (pcnt[i] != 1 || pfirst[i] != base + exp_c[i]) begin
        $display("FAIL cont_p%0d: got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", i, pcnt[i],
                 pfirst[i], base + exp_c[i]);
        bad++;
      end
      total++;
    end
  endtask

  task automatic test_retrigger();
    int base;
    set_dly(0, 10);
    for (int i = 1; i < 4; i++) set_dly(i, 3);
    clr_mon();
    base = cyc;
    pulse(8'h01);
    repeat (3) tick();
    pulse(8'h01);
    pulse(8'h02);
    pulse(8'h04);
    if (full !== 1'b0) begin $display("FAIL retrig_full_c7: got %b want 0", full); bad++; end
    total++;
    pulse(8'h08);
    if (full !== 1'b1) begin $display("FAIL retrig_full_c8: got %b want 1", full); bad++; end
    total++;
    while (cyc < base + 20) tick();
    if (pcnt[0] != 1 || pfirst[0] != base + 14) begin
      $display("FAIL retrig_p0: got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", pcnt[0], pfirst[0],
               base + 14);
      bad++;
    end
    total++;
    if (pfirst[3] != base + 10) begin
      $display("FAIL retrig_p3: got %0d want %0d", pfirst[3], base + 10); bad++;
    end
    total++;
  endtask

  task automatic test_expiry_retrig();
    int base;
    set_dly(1, 6);
    clr_mon();
    base = cyc;
    pulse(8'h02);
    while (cyc < base + 6) tick();
    pulse(8'h02);
    while (cyc < base + 16) tick();
    if (pcnt[1] != 2) begin $display("FAIL exp_retrig_cnt: got %0d want 2", pcnt[1]); bad++; end
    total++;
    if (pfirst[1] != base + 6) begin
      $display("FAIL exp_retrig_first: got %0d want %0d", pfirst[1], base + 6); bad++;
    end
    total++;
    if (plast[1] != base + 12) begin
      $display("FAIL exp_retrig_second: got %0d want %0d", plast[1], base + 12); bad++;
    end
    total++;
  endtask

`ifdef DLY_SCHED_ABORT_EN
  task automatic test_abort();
    int base;
    set_dly(3, 6);
    clr_mon();
    base = cyc;
    pulse(8'h08);
    while (cyc < base + 5) tick();
    abort = 8'h08;
    tick();
    abort = '0;
    if (l[3] !== 1'b0) begin $display("FAIL abort_l3: got %b want 0", l[3]); bad++; end
    total++;
    set_dly(3, 2);
    base = cyc;
    pulse(8'h08);
    repeat (4) tick();
    if (pcnt[3] != 1 || pfirst[3] != base + 2) begin
      $display("FAIL abort_p3: got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", pcnt[3], pfirst[3],
               base + 2);
      bad++;
    end
    total++;
  endtask
`endif

  task automatic test_reset_mid();
    set_dly(4, 8);
    clr_mon();
    pulse(8'h10);
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    if (l !== 8'h00) begin $display("FAIL midrst_l: got %b want %b", l, 8'h00); bad++; end
    total++;
    if (p !== 8'h00) begin $display("FAIL midrst_p: got %b want %b", p, 8'h00); bad++; end
    total++;
    tick();
    tick();
    reset_n = 1'b1;
    repeat (15) tick();
    if (pcnt[4] != 0) begin $display("FAIL midrst_no_p: got %0d want 0", pcnt[4]); bad++; end
    total++;
    if (l !== 8'h00) begin $display("FAIL midrst_l_after: got %b want %b", l, 8'h00); bad++; end
    total++;
  endtask

  initial begin
    clr_mon();
    test_reset();
    test_single();
    test_boundary();
    test_contention();
    test_retrigger();
    test_expiry_retrig();
`ifdef DLY_SCHED_ABORT_EN
    test_abort();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
